// File: rtl/periph_hid_xbar_pkg.sv
// Shared types and field positions for the hid_* peripheral crossbar.
// Drop-counter fields are only live when PERIPH_HID_XBAR_DROP_CNT_EN is defined.
package periph_hid_xbar_pkg;

  typedef enum logic [0:0] {
    REG_EVT  = 1'b0,
    REG_CTRL = 1'b1
  } region_e;

  localparam int unsigned EVT_EMPTY_BIT  = 31;
  localparam int unsigned EVT_DROP_LSB   = 24;
  localparam int unsigned EVT_DATA_MAX_W = 24;
  localparam int unsigned DROP_W         = 7;

  localparam logic EVT_OFF_DATA  = 1'b0;
  localparam logic EVT_OFF_LEVEL = 1'b1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/periph_evt_fifo.sv
// Synchronous event FIFO: wrap-bit pointers give full/empty/level without a separate counter.
// The caller guarantees push only when space exists (or a pop frees a slot) and pop only when non-empty.
module periph_evt_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_W     = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_push,
  input  logic [FIFO_W-1:0]             i_data,
  input  logic                          i_pop,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic [FIFO_W-1:0]             o_head
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [FIFO_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/periph_hid_xbar.sv
// hid_* bus crossbar: event FIFO (region 0), control bank (region 1), external slaves (2..N-1),
// all reads returned through one fixed-latency pipeline. Optional macro: PERIPH_HID_XBAR_DROP_CNT_EN.
module periph_hid_xbar
  import periph_hid_xbar_pkg::*;
#(
  parameter int unsigned NREGION    = 4,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned CTRL_REGS  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_W     = 16,
  parameter int unsigned EXT_RD_LAT = 1
) (
  input  logic                      msoc_clk,
  input  logic                      rst,
  input  logic                      hid_en,
  input  logic [3:0]                hid_we,
  input  logic [ADDR_W-1:0]         hid_addr,
  input  logic [31:0]               hid_wrdata,
  output logic [31:0]               hid_rddata,
  output logic                      hid_rvalid,
  input  logic                      evt_valid,
  input  logic [FIFO_W-1:0]         evt_data,
  output logic                      evt_ready,
  output logic [CTRL_REGS*32-1:0]   ctrl_q,
  output logic [NREGION-1:0]        ext_en,
  output logic [3:0]                ext_we,
  input  logic [NREGION*32-1:0]     ext_rdata
);

  localparam int unsigned RIDX_W = $clog2(NREGION);
  localparam int unsigned CIDX_W = $clog2(CTRL_REGS);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LAST   = EXT_RD_LAT;

  // ---------------------------------------------------------------- decode
  logic [RIDX_W-1:0] w_region;
  logic [CIDX_W-1:0] w_cidx;
  logic              w_evt_off;
  logic              w_rd;
  logic              w_wr;
  logic              w_is_evt;
  logic              w_is_ctrl;
  logic              w_is_ext;

  assign w_region  = hid_addr[ADDR_W-1 -: RIDX_W];
  assign w_cidx    = hid_addr[2 +: CIDX_W];
  assign w_evt_off = hid_addr[2];
  assign w_rd      = hid_en & (hid_we == '0);
  assign w_wr      = hid_en & (|hid_we);
  assign w_is_evt  = (w_region == RIDX_W'(REG_EVT));
  assign w_is_ctrl = (w_region == RIDX_W'(REG_CTRL));
  assign w_is_ext  = ~w_is_evt & ~w_is_ctrl;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ext_en = '0;
    if (hid_en && w_is_ext) ext_en[w_region] = 1'b1;
  end

  assign ext_we = (|ext_en) ? hid_we : 4'b0000;

  // ---------------------------------------------------------------- event FIFO
  logic              w_full;
  logic              w_empty;
  logic [LVL_W-1:0]  w_level;
  logic [FIFO_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic [DROP_W-1:0] w_drop_cnt;

  assign w_pop = w_rd & w_is_evt & (w_evt_off == EVT_OFF_DATA) & ~w_empty;

`ifdef PERIPH_HID_XBAR_DROP_CNT_EN
  logic              w_drop_clr;
  logic [DROP_W-1:0] r_drop_cnt;

  assign evt_ready  = 1'b1;
  // A pop in the same cycle frees the slot the full-state push would have lost.
  assign w_push     = evt_valid & (~w_full | w_pop);
  assign w_drop_clr = w_wr & w_is_evt & (w_evt_off == EVT_OFF_DATA);

  always_ff @(posedge msoc_clk) begin
    if (rst)                               r_drop_cnt <= '0;
    else if (w_drop_clr)                   r_drop_cnt <= '0;
    else if (evt_valid & w_full & ~w_pop)  r_drop_cnt <= sat_inc(r_drop_cnt);
  end

  assign w_drop_cnt = r_drop_cnt;
`else
  assign evt_ready  = ~w_full;
  assign w_push     = evt_valid & ~w_full;
  assign w_drop_cnt = '0;
`endif

  periph_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_W     (FIFO_W)
  ) u_evt_fifo (
    .i_clk   (msoc_clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (evt_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  (w_head)
  );

  // ---------------------------------------------------------------- control bank
  logic [31:0] r_ctrl [CTRL_REGS];

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      for (int i = 0; i < CTRL_REGS; i++) r_ctrl[i] <= '0;
    end else if (w_wr && w_is_ctrl) begin
      for (int b = 0; b < 4; b++) begin
        if (hid_we[b]) r_ctrl[w_cidx][b*8 +: 8] <= hid_wrdata[b*8 +: 8];
      end
    end
  end

  for (genvar g = 0; g < CTRL_REGS; g++) begin : g_ctrl_q
    assign ctrl_q[g*32 +: 32] = r_ctrl[g];
  end

  // ---------------------------------------------------------------- internal read mux
  logic [31:0] w_evt_word;
  logic [31:0] w_int_rdata;

  always_comb begin
    w_evt_word                          = '0;
    w_evt_word[EVT_EMPTY_BIT]           = w_empty;
    w_evt_word[EVT_DROP_LSB +: DROP_W]  = w_drop_cnt;
    if (!w_empty) w_evt_word[FIFO_W-1:0] = w_head;

    w_int_rdata = '0;
    if (w_is_evt)       w_int_rdata = (w_evt_off == EVT_OFF_LEVEL) ? 32'(w_level) : w_evt_word;
    else if (w_is_ctrl) w_int_rdata = r_ctrl[w_cidx];
  end

  // ---------------------------------------------------------------- read pipeline
  // Stages 0..LAST-1 plus the output register give EXT_RD_LAT+1 cycles for every region.
  logic              r_pipe_vld [LAST];
  logic [RIDX_W-1:0] r_pipe_reg [LAST];
  logic [31:0]       r_pipe_dat [LAST];
  logic              r_rvalid;
  logic [31:0]       r_rddata;
  logic              w_tail_ext;
  logic [31:0]       w_ext_word;

  assign w_tail_ext = (r_pipe_reg[LAST-1] != RIDX_W'(REG_EVT)) &&
                      (r_pipe_reg[LAST-1] != RIDX_W'(REG_CTRL));

  always_comb begin
    w_ext_word = '0;
    for (int r = 2; r < NREGION; r++) begin
      if (r_pipe_reg[LAST-1] == RIDX_W'(r)) w_ext_word = ext_rdata[r*32 +: 32];
    end
  end

  always_ff @(posedge msoc_clk) begin
    if (rst) begin
      for (int s = 0; s < LAST; s++) begin
        r_pipe_vld[s] <= 1'b0;
        r_pipe_reg[s] <= '0;
        r_pipe_dat[s] <= '0;
      end
      r_rvalid <= 1'b0;
      r_rddata <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd;
      r_pipe_reg[0] <= w_region;
      r_pipe_dat[0] <= w_int_rdata;
      for (int s = 1; s < LAST; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_reg[s] <= r_pipe_reg[s-1];
        r_pipe_dat[s] <= r_pipe_dat[s-1];
      end
      r_rvalid <= r_pipe_vld[LAST-1];
      if (r_pipe_vld[LAST-1]) r_rddata <= w_tail_ext ? w_ext_word : r_pipe_dat[LAST-1];
    end
  end

  assign hid_rvalid = r_rvalid;
  assign hid_rddata = r_rddata;

  // Byte-offset bits, unused address bits and the internal regions' ext_rdata slots are ignored.
  logic w_unused;
  assign w_unused = ^{hid_addr, ext_rdata[2*32-1:0]};

endmodule

// File: tb/tb_periph_hid_xbar.sv
// Self-checking bench for periph_hid_xbar: vector table plus hand sequences, scoreboard on read responses.
module tb_periph_hid_xbar;

  localparam int unsigned NREG  = 4;
  localparam int unsigned AW    = 17;
  localparam int unsigned NCTRL = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = 16;
  localparam int unsigned LAT   = 3;

`ifdef PERIPH_HID_XBAR_DROP_CNT_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  logic                  msoc_clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  hid_en = 1'b0;
  logic [3:0]            hid_we = '0;
  logic [AW-1:0]         hid_addr = '0;
  logic [31:0]           hid_wrdata = '0;
  logic [31:0]           hid_rddata;
  logic                  hid_rvalid;
  logic                  evt_valid = 1'b0;
  logic [FW-1:0]         evt_data = '0;
  logic                  evt_ready;
  logic [NCTRL*32-1:0]   ctrl_q;
  logic [NREG-1:0]       ext_en;
  logic [3:0]            ext_we;
  logic [NREG*32-1:0]    ext_rdata;

  periph_hid_xbar #(
    .NREGION    (NREG),
    .ADDR_W     (AW),
    .CTRL_REGS  (NCTRL),
    .FIFO_DEPTH (DEPTH),
    .FIFO_W     (FW),
    .EXT_RD_LAT (LAT)
  ) dut (
    .msoc_clk   (msoc_clk),
    .rst        (rst),
    .hid_en     (hid_en),
    .hid_we     (hid_we),
    .hid_addr   (hid_addr),
    .hid_wrdata (hid_wrdata),
    .hid_rddata (hid_rddata),
    .hid_rvalid (hid_rvalid),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .ctrl_q     (ctrl_q),
    .ext_en     (ext_en),
    .ext_we     (ext_we),
    .ext_rdata  (ext_rdata)
  );

  always #5 msoc_clk = ~msoc_clk;

  int unsigned cyc = 0;
  always @(posedge msoc_clk) cyc <= cyc + 1;

  // External slave model: data is valid only in the cycle exactly LAT cycles after its enable.
  logic [NREG-1:0] slv_en [LAT];
  always @(posedge msoc_clk) begin
    slv_en[0] <= ext_en;
    for (int k = 1; k < LAT; k++) slv_en[k] <= slv_en[k-1];
  end
  always_comb begin
    ext_rdata = '0;
    for (int r = 0; r < NREG; r++)
      ext_rdata[r*32 +: 32] = slv_en[LAT-1][r] ? (32'hCAFE0000 | 32'(r)) : 32'hDEADBEEF;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int unsigned due;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  // Response monitor: rvalid must rise exactly on the due cycle of the oldest outstanding read.
  always @(negedge msoc_clk) begin
    logic  exp_v;
    exp_t  e;
    exp_v = (sb_q.size() != 0) && (sb_q[0].due == cyc);
    if (hid_rvalid || exp_v) begin
      check(exp_v ? {"rvalid_", sb_q[0].name} : "rvalid_unexpected", 32'(hid_rvalid), 32'(exp_v));
      if (exp_v) begin
        e = sb_q.pop_front();
        if (hid_rvalid) check({"rdata_", e.name}, hid_rddata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge msoc_clk);
    #1;
  endtask

  function automatic logic [AW-1:0] mk_addr(input int unsigned region, input int unsigned word);
    return AW'((region << 15) | (word << 2));
  endfunction

  task automatic set_req(input int unsigned region, input int unsigned word, input logic [3:0] we,
                         input logic [31:0] wd, input logic [31:0] exp, input string name,
                         input bit track = 1'b1);
    exp_t e;
    hid_en     = 1'b1;
    hid_we     = we;
    hid_addr   = mk_addr(region, word);
    hid_wrdata = wd;
    if (we == 4'b0000 && track) begin
      e.data = exp;
      e.due  = cyc + 1 + LAT;
      e.name = name;
      sb_q.push_back(e);
    end
  endtask

  task automatic clr_req();
    hid_en = 1'b0;
    hid_we = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
    repeat (LAT + 2) step();
  endtask

  typedef struct {
    int unsigned region;
    int unsigned word;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{1, 3, 4'hF, 32'h11223344, 32'h0};
    vecs[1]  = '{1, 3, 4'h2, 32'hAABBCCDD, 32'h0};
    vecs[2]  = '{1, 3, 4'h0, 32'h0,        32'h1122CC44};
    vecs[3]  = '{1, 0, 4'hF, 32'h0BADF00D, 32'h0};
    vecs[4]  = '{2, 0, 4'h0, 32'h0,        32'hCAFE0002};
    vecs[5]  = '{1, 0, 4'h0, 32'h0,        32'h0BADF00D};
    vecs[6]  = '{3, 0, 4'h0, 32'h0,        32'hCAFE0003};
    vecs[7]  = '{1, 5, 4'h9, 32'hA1B2C3D4, 32'h0};
    vecs[8]  = '{1, 5, 4'h0, 32'h0,        32'hA10000D4};
    vecs[9]  = '{0, 1, 4'h0, 32'h0,        32'h00000000};
    vecs[10] = '{0, 0, 4'h0, 32'h0,        32'h80000000};
    vecs[11] = '{2, 4, 4'hF, 32'h12345678, 32'h0};
    vecs[12] = '{1, 3, 4'hC, 32'h55667788, 32'h0};
    vecs[13] = '{1, 3, 4'h0, 32'h0,        32'h5566CC44};

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    check("rst_rvalid", 32'(hid_rvalid), 32'd0);
    check("rst_rddata", hid_rddata, 32'd0);
    check("rst_ctrl_q_any", 32'(|ctrl_q), 32'd0);
    check("rst_evt_ready", 32'(evt_ready), 32'd1);

    // Vector table, one request per cycle
    for (int i = 0; i < 14; i++) begin
      step();
      set_req(vecs[i].region, vecs[i].word, vecs[i].we, vecs[i].wdata, vecs[i].exp,
              $sformatf("vec%0d", i));
    end
    step();
    clr_req();
    drain();
    check("ctrl_q_reg3", ctrl_q[3*32 +: 32], 32'h5566CC44);
    check("ctrl_q_reg0", ctrl_q[0*32 +: 32], 32'h0BADF00D);
    check("ctrl_q_reg5", ctrl_q[5*32 +: 32], 32'hA10000D4);

    // External enable decode is combinational in the request cycle
    step();
    hid_en = 1'b1; hid_we = 4'b0101; hid_addr = mk_addr(3, 0);
    #1;
    check("ext_en_r3", 32'(ext_en), 32'b1000);
    check("ext_we_r3", 32'(ext_we), 32'b0101);
    hid_addr = mk_addr(1, 7);
    #1;
    check("ext_en_r1", 32'(ext_en), 32'b0000);
    check("ext_we_r1", 32'(ext_we), 32'b0000);
    hid_en = 1'b0; hid_addr = mk_addr(3, 0);
    #1;
    check("ext_en_idle", 32'(ext_en), 32'b0000);
    hid_we = '0;

    // Event FIFO order and pop-on-read
    step(); evt_valid = 1'b1; evt_data = 16'h0041;
    check("push41_ready", 32'(evt_ready), 32'd1);
    step(); evt_data = 16'h0042;
    check("push42_ready", 32'(evt_ready), 32'd1);
    step(); evt_valid = 1'b0;
    set_req(0, 0, 4'h0, 0, 32'h00000041, "evt_pop0");
    step(); set_req(0, 0, 4'h0, 0, 32'h00000042, "evt_pop1");
    step(); set_req(0, 0, 4'h0, 0, 32'h80000000, "evt_pop_empty");
    step(); clr_req();
    drain();

    // Overflow: six pushes into a four-entry FIFO
    step();
    for (int i = 0; i < 6; i++) begin
      evt_valid = 1'b1;
      evt_data  = FW'(16'h0100 + i);
      check($sformatf("ovf_ready%0d", i), 32'(evt_ready), (DROP_MODE || i < 4) ? 32'd1 : 32'd0);
      step();
    end
    evt_valid = 1'b0;
    set_req(0, 1, 4'h0, 0, 32'd4, "ovf_level");
    step(); set_req(0, 0, 4'h0, 0, DROP_MODE ? 32'h02000100 : 32'h00000100, "ovf_head_drop");
    step(); set_req(0, 0, 4'hF, 0, 0, "drop_clr");
    step(); set_req(0, 0, 4'h0, 0, 32'h00000101, "after_clr");
    step(); clr_req();
    drain();

    // Full FIFO with a simultaneous push and pop
    step(); evt_valid = 1'b1; evt_data = 16'h0104;
    check("refill0_ready", 32'(evt_ready), 32'd1);
    step(); evt_data = 16'h0105;
    check("refill1_ready", 32'(evt_ready), 32'd1);
    step(); evt_data = 16'h01FF;
    set_req(0, 0, 4'h0, 0, 32'h00000102, "full_pop");
    check("full_pop_ready", 32'(evt_ready), DROP_MODE ? 32'd1 : 32'd0);
    step(); evt_valid = 1'b0;
    set_req(0, 1, 4'h0, 0, DROP_MODE ? 32'd4 : 32'd3, "full_pop_level");
    step(); clr_req();
    drain();

    // Reset one cycle after a read request: the read is discarded
    step(); set_req(1, 3, 4'h0, 0, 0, "killed", 1'b0);
    step(); clr_req(); rst = 1'b1;
    step(); rst = 1'b0;
    check("midrst_rvalid", 32'(hid_rvalid), 32'd0);
    check("midrst_rddata", hid_rddata, 32'd0);
    check("midrst_ctrl_q_any", 32'(|ctrl_q), 32'd0);
    step(); set_req(0, 1, 4'h0, 0, 32'd0, "midrst_level");
    step(); set_req(0, 0, 4'h0, 0, 32'h80000000, "midrst_evt");
    step(); set_req(1, 3, 4'h0, 0, 32'd0, "midrst_ctrl3");
    step(); clr_req();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
